// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// Word-addressed request with byte strobes; one request outstanding at a time.
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory access per start, with byte-lane
// store steering, load sign/zero extension and fault reporting.
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned,
    output logic              illegal,
    lsu_if.master             mem
);

    // state  | meaning
    // S_IDLE | waiting for start; decodes and latches the request
    // S_REQ  | mem_req held with stable bus outputs until mem_ready
    // S_DONE | one-cycle done pulse; fault flags valid here
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              armed;
    logic              accept;
    logic              bad_op;
    logic              bad_align;
    logic              fault;
    logic [3:0]        strb_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] load_ext;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    logic [2:0]        f3_q;
    logic [1:0]        addr_lo_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        strb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mis_q;
    logic              ill_q;

    always_comb begin
        bad_op = 1'b0;
        if (is_load == is_store) begin
            bad_op = 1'b1;
        end else if (is_load) begin
            bad_op = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else begin
            bad_op = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end
    end

    assign bad_align = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign fault     = bad_op || bad_align;
    assign accept    = (state == S_IDLE) && start && armed;

    // Store data is replicated across lanes so the strobes alone pick the bytes.
    always_comb begin
        strb_nxt  = 4'b0000;
        wdata_nxt = wdata;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    strb_nxt  = 4'b0001 << addr[1:0];
                    wdata_nxt = {4{wdata[7:0]}};
                end
                2'b01: begin
                    strb_nxt  = 4'b0011 << addr[1:0];
                    wdata_nxt = {2{wdata[15:0]}};
                end
                default: begin
                    strb_nxt  = 4'b1111;
                    wdata_nxt = wdata;
                end
            endcase
        end
    end

    always_comb begin
        byte_sel = mem.mem_rdata[7:0];
        case (addr_lo_q)
            2'd0: byte_sel = mem.mem_rdata[7:0];
            2'd1: byte_sel = mem.mem_rdata[15:8];
            2'd2: byte_sel = mem.mem_rdata[23:16];
            2'd3: byte_sel = mem.mem_rdata[31:24];
            default: byte_sel = mem.mem_rdata[7:0];
        endcase
        half_sel = addr_lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

        load_ext = mem.mem_rdata;
        case (f3_q)
            3'b000: load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001: load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100: load_ext = {24'd0, byte_sel};
            3'b101: load_ext = {16'd0, half_sel};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = fault ? S_DONE : S_REQ;
            S_REQ:  if (mem.mem_ready) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Blocks a start that is already high on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q      <= 3'd0;
            addr_lo_q <= 2'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            strb_q    <= 4'd0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mis_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            if (accept) begin
                ill_q <= bad_op;
                mis_q <= !bad_op && bad_align;
                if (!fault) begin
                    f3_q      <= funct3;
                    addr_lo_q <= addr[1:0];
                    we_q      <= is_store;
                    addr_q    <= {addr[ADDR_W-1:2], 2'b00};
                    strb_q    <= strb_nxt;
                    wdata_q   <= wdata_nxt;
                end
            end
            if ((state == S_REQ) && mem.mem_ready && !we_q) begin
                rdata_q <= load_ext;
            end
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign misaligned    = done && mis_q;
    assign illegal       = done && ill_q;
    assign rdata         = rdata_q;

    assign mem.mem_req   = (state == S_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wstrb = strb_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the RV32I datapath.
- Consumes alu_out as the effective address and performs a single data-memory access over a req/ready handshake.
- Generates byte strobes and lane-aligned write data for stores; sign- or zero-extends read data for loads.
- Holds the pipeline with busy and signals completion with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, address width; addr and mem_addr use this width.
- DATA_W, 32, data width; fixed at 32 for RV32I, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- is_load  input  1  operation is a load.
- is_store  input  1  operation is a store.
- funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  ADDR_W  effective address from alu_out.
- wdata  input  32  store data (rs2).
- busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result; valid when done=1, then held.
- misaligned  output  1  with done: address misaligned, no bus access made.
- illegal  output  1  with done: bad funct3 for the op, or is_load and is_store both high, or neither high.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- mem_wstrb  output  4  byte-enable strobes.
- mem_wdata  output  32  lane-replicated store data.
- mem_rdata  input  32  read data, valid when mem_ready=1.
- mem_ready  input  1  bus accepts/completes the current request this cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, rdata=0. mem_req drops immediately, including mid-transaction; the in-flight access is abandoned.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1, operation legal and aligned: latch op, funct3, addr[1:0], mem_addr, mem_we, mem_wstrb, mem_wdata. Go to REQ.
- IDLE, start=1, fault: go to DONE with misaligned or illegal set. No mem_req is issued. illegal takes priority over misaligned.
- REQ: mem_req=1. All mem_* outputs stay stable until mem_ready=1. On mem_ready=1, capture the extended read data for loads and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. misaligned and illegal are valid only while done=1.
- Minimum latency: start accepted at edge T, mem_req high in cycle T+1, mem_ready=1 in T+1, done high in cycle T+2.
- start while busy or in DONE is ignored and not queued.
- Misalignment: H/HU and SH require addr[0]=0. W and SW require addr[1:0]=00.
- Legal funct3 values:
  - loads: 000, 001, 010, 100, 101.
  - stores: 000, 001, 010.
  - all others are illegal.
- Store strobes:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111.
- Loads: mem_we=0, mem_wstrb=0000.
- Load extract: select byte lane addr[1:0] or halfword lane addr[1]. B and H sign-extend; BU and HU zero-extend.
- rdata holds its last load value across stores and faults. It is updated only on load completion.
- mem_ready while not in REQ is ignored.
- start coincident with reset release is ignored; the first start is accepted after rst_n has been high for at least one edge.

Test Plan:
- LW: addr=0x100, mem_rdata=0xDEADBEEF, mem_ready=1 in the first REQ cycle -> mem_addr=0x100, done at T+2, rdata=0xDEADBEEF, busy high for 2 cycles.
- LB and LBU: addr=0x103, mem_rdata=0x80xxxxxx -> LB gives rdata=0xFFFFFF80; LBU gives 0x00000080. LH at 0x102 with mem_rdata=0x7FFFxxxx gives rdata=0x00007FFF.
- SB and SH: SB addr=0x0A1, wdata=0x123456AB -> mem_wstrb=0010, mem_wdata=0xABABABAB, mem_addr=0x0A0, mem_we=1. SH addr=0x0A2 -> mem_wstrb=1100.
- Wait states: mem_ready held low for 3 cycles -> mem_req and all mem_* outputs stay stable; a start pulse mid-wait is ignored; done arrives 1 cycle after mem_ready.
- Faults: LW at addr=0x102 -> done+misaligned with mem_req never asserted. Store with funct3=100 -> done+illegal. is_load=is_store=1 -> done+illegal. rdata unchanged in all three cases.
- Reset mid-op: rst_n low while in REQ with mem_ready=0 -> mem_req=0 immediately and all outputs 0. After release, a new LW completes normally.
